mdu_ctrl: RTL and testbench

Sequencing controller for the shared iterative multiply/divide unit used by RV64 M-extension ops (MUL, DIV, DIVU, REM, REMU and their W forms). Sits in execute beside the single-cycle ALU. Accepts one operand pair from the decode operand-select stage, runs a radix-2 shift-subtract or shift-add loop, applies RISC-V sign and special-case rules, and holds the result until the writeback side takes it. While an operation is in flight, `busy` stalls the front of the pipeline.

---
 rtl/pipes.sv | 42 ++++
 rtl/mdu_divstep.sv | 26 ++
 rtl/mdu_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared types for the execute-stage multiply/divide sequencer.
package pipes;

   typedef enum logic [2:0] {
      MDU_MUL  = 3'd0,
      MDU_DIV  = 3'd1,
      MDU_DIVU = 3'd2,
      MDU_REM  = 3'd3,
      MDU_REMU = 3'd4
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

   localparam int MDU_CNT_W = 6;

   function automatic logic op_is_signed(input mdu_op_t op);
      case (op)
         MDU_DIV, MDU_REM: op_is_signed = 1'b1;
         default:          op_is_signed = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_rem(input mdu_op_t op);
      case (op)
         MDU_REM, MDU_REMU: op_is_rem = 1'b1;
         default:           op_is_rem = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_div(input mdu_op_t op);
      case (op)
         MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: op_is_div = 1'b1;
         default:                              op_is_div = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring shift-subtract division step on unsigned magnitudes.
module mdu_divstep #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] dvs,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] sh_s;

   // Shift the next dividend bit into the remainder and trial-subtract the divisor.
   always_comb begin
      sh_s = {rem, quo[XLEN-1]};
      if (sh_s >= {1'b0, dvs}) begin
         rem_next = sh_s[XLEN-1:0] - dvs;
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = sh_s[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit (RV64 M ops and W forms).
// Build option MDU_FAST_MUL_EN: MUL/MULW complete with a single-cycle multiplier at accept.
module mdu_ctrl
   import pipes::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            busy
);

   function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

   mdu_state_t           state_r;
   mdu_op_t              op_s, op_r;
   logic                 word_r, neg_a_r, neg_b_r;
   logic [XLEN-1:0]      rem_r, quo_r, dvs_r;
   logic [MDU_CNT_W-1:0] cnt_r;
   logic                 in_ready_r, out_valid_r, busy_r;
   logic [XLEN-1:0]      out_data_r;

   logic                 sgn_s, neg_a_s, neg_b_s, dz_s, ovf_s, special_s;
   logic [XLEN-1:0]      a_s, b_s, mag_a_s, mag_b_s, min_s, spec_raw_s, spec_res_s;
   logic [XLEN-1:0]      step_rem_s, step_quo_s, mul_acc_s, fix_raw_s, fix_res_s;
`ifdef MDU_FAST_MUL_EN
   logic [XLEN-1:0]      prod_s, fast_res_s;
`endif

   // Operand preparation and special-case detection for the request on the input.
   always_comb begin
      op_s  = mdu_op_t'(in_op);
      sgn_s = op_is_signed(op_s);
      if (in_word) begin
         a_s   = sgn_s ? wext(in_a) : {{(XLEN-32){1'b0}}, in_a[31:0]};
         b_s   = sgn_s ? wext(in_b) : {{(XLEN-32){1'b0}}, in_b[31:0]};
         min_s = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      end else begin
         a_s   = in_a;
         b_s   = in_b;
         min_s = {1'b1, {(XLEN-1){1'b0}}};
      end
      neg_a_s   = sgn_s & a_s[XLEN-1];
      neg_b_s   = sgn_s & b_s[XLEN-1];
      mag_a_s   = neg_a_s ? -a_s : a_s;
      mag_b_s   = neg_b_s ? -b_s : b_s;
      dz_s      = (b_s == {XLEN{1'b0}});
      ovf_s     = sgn_s & (a_s == min_s) & (b_s == {XLEN{1'b1}});
      special_s = op_is_div(op_s) & (dz_s | ovf_s);
      if (op_is_rem(op_s)) begin
         spec_raw_s = dz_s ? a_s : {XLEN{1'b0}};
      end else begin
         spec_raw_s = dz_s ? {XLEN{1'b1}} : a_s;
      end
      spec_res_s = in_word ? wext(spec_raw_s) : spec_raw_s;
`ifdef MDU_FAST_MUL_EN
      prod_s     = a_s * b_s;
      fast_res_s = in_word ? wext(prod_s) : prod_s;
`endif
   end

   mdu_divstep #(.XLEN(XLEN)) u_divstep (
      .rem      (rem_r),
      .quo      (quo_r),
      .dvs      (dvs_r),
      .rem_next (step_rem_s),
      .quo_next (step_quo_s)
   );

   // Shift-add step and final sign correction of the iterated result.
   always_comb begin
      mul_acc_s = quo_r[0] ? (rem_r + dvs_r) : rem_r;
      case (op_r)
         MDU_DIV:  fix_raw_s = (neg_a_r ^ neg_b_r) ? -quo_r : quo_r;
         MDU_DIVU: fix_raw_s = quo_r;
         MDU_REM:  fix_raw_s = neg_a_r ? -rem_r : rem_r;
         MDU_REMU: fix_raw_s = rem_r;
         MDU_MUL:  fix_raw_s = rem_r;
         default:  fix_raw_s = {XLEN{1'b0}};
      endcase
      fix_res_s = word_r ? wext(fix_raw_s) : fix_raw_s;
   end

   // Control FSM with registered handshake outputs; flush overrides every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         op_r        <= MDU_MUL;
         word_r      <= 1'b0;
         neg_a_r     <= 1'b0;
         neg_b_r     <= 1'b0;
         rem_r       <= {XLEN{1'b0}};
         quo_r       <= {XLEN{1'b0}};
         dvs_r       <= {XLEN{1'b0}};
         cnt_r       <= {MDU_CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= {XLEN{1'b0}};
      end else if (flush) begin
         state_r     <= IDLE;
         cnt_r       <= {MDU_CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  op_r       <= op_s;
                  word_r     <= in_word;
                  neg_a_r    <= neg_a_s;
                  neg_b_r    <= neg_b_s;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  if (special_s) begin
                     state_r     <= DONE;
                     out_data_r  <= spec_res_s;
                     out_valid_r <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                  end else if (op_s == MDU_MUL) begin
                     state_r     <= DONE;
                     out_data_r  <= fast_res_s;
                     out_valid_r <= 1'b1;
`endif
                  end else begin
                     state_r <= BUSY;
                     cnt_r   <= in_word ? 6'd31 : 6'd63;
                     rem_r   <= {XLEN{1'b0}};
                     if (op_s == MDU_MUL) begin
                        quo_r <= b_s;
                        dvs_r <= a_s;
                     end else begin
                        // W divides start with the 32-bit magnitude at the top so 32 steps consume it.
                        quo_r <= in_word ? {mag_a_s[31:0], {(XLEN-32){1'b0}}} : mag_a_s;
                        dvs_r <= mag_b_s;
                     end
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (op_r == MDU_MUL) begin
                  rem_r <= mul_acc_s;
                  quo_r <= {1'b0, quo_r[XLEN-1:1]};
                  dvs_r <= {dvs_r[XLEN-2:0], 1'b0};
               end else begin
                  rem_r <= step_rem_s;
                  quo_r <= step_quo_s;
               end
               if (cnt_r == {MDU_CNT_W{1'b0}}) begin
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r - {{(MDU_CNT_W-1){1'b0}}, 1'b1};
               end
            end
            FIX: begin
               out_data_r  <= fix_res_s;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic        in_word;
   logic [63:0] in_a, in_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   mdu_ctrl #(.XLEN(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_word   (in_word),
      .in_a      (in_a),
      .in_b      (in_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics using native integer arithmetic.
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      int          sa32, sb32;
      int unsigned ua32, ub32;
      longint      sa, sb;
      longint unsigned ua, ub;
      logic [31:0] r32;
      logic [63:0] r;
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      sa = a; sb = b; ua = a; ub = b;
      r32 = 32'd0; r = 64'd0;
      if (w) begin
         case (op)
            3'd0: r32 = ua32 * ub32;
            3'd1: if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                  else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                  else r32 = sa32 / sb32;
            3'd2: if (ub32 == 0) r32 = 32'hFFFF_FFFF; else r32 = ua32 / ub32;
            3'd3: if (ub32 == 0) r32 = ua32;
                  else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
                  else r32 = sa32 % sb32;
            3'd4: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
            default: r32 = 32'd0;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         case (op)
            3'd0: r = ua * ub;
            3'd1: if (ub == 0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                  else if (ua == 64'h8000_0000_0000_0000 && ub == 64'hFFFF_FFFF_FFFF_FFFF) r = ua;
                  else r = sa / sb;
            3'd2: if (ub == 0) r = 64'hFFFF_FFFF_FFFF_FFFF; else r = ua / ub;
            3'd3: if (ub == 0) r = ua;
                  else if (ua == 64'h8000_0000_0000_0000 && ub == 64'hFFFF_FFFF_FFFF_FFFF) r = 64'd0;
                  else r = sa % sb;
            3'd4: if (ub == 0) r = ua; else r = ua % ub;
            default: r = 64'd0;
         endcase
      end
      return r;
   endfunction

   // Edges counted from the accept edge (as 1) until out_valid is first seen.
   function automatic int ref_lat(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic zero_b, ovf;
      zero_b = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf = (op == 3'd1 || op == 3'd3) &&
            (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
      if (op != 3'd0 && (zero_b || ovf)) return 1;
`ifdef MDU_FAST_MUL_EN
      if (op == 3'd0) return 1;
`endif
      return w ? 34 : 66;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int hold, input string tag);
      logic [63:0] exp;
      int          lat;
      exp = ref_res(op, w, a, b);
      chk({tag, "_rdy0"}, in_ready, 1'b1);
      in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_rdy1"}, in_ready, 1'b0);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, w, a, b)));
      chk({tag, "_data"}, out_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold"}, out_data, exp);
         chk({tag, "_holdv"}, {in_ready, out_valid, busy}, 3'b011);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      int          vcount;
      reset = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_word = 1'b0;
      in_a = 64'd0; in_b = 64'd0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
      chk("rst_data", out_data, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "div_m7_2");
      run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "rem_m7_2");
      run_op(3'd4, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'h1234_5678_0000_0003, 0, "remuw");
      run_op(3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, "divw_ovf");
      run_op(3'd1, 1'b0, 64'd5, 64'd0, 0, "div_dz");
      run_op(3'd3, 1'b0, 64'd5, 64'd0, 0, "rem_dz");
      run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div_ovf");
      run_op(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, "rem_ovf");
      run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 3, "mul_3_m4");

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 4));
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: begin b[31:0] = 32'd0; if (!w) b = 64'd0; end
            1: begin
                  if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
                  else begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
               end
            2: b = b >> $urandom_range(0, 62);
            3: a = a >> $urandom_range(0, 62);
            default: ;
         endcase
         run_op(op, w, a, b, $urandom_range(0, 2), "rnd");
      end

      // Flush a 64-bit divide mid-iteration.
      in_valid = 1'b1; in_op = 3'd1; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_idle", {in_ready, out_valid, busy}, 3'b100);
      vcount = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (out_valid) vcount++;
      end
      chk("flush_nopulse", 64'(vcount), 64'd0);
      run_op(3'd2, 1'b0, 64'd1000, 64'd7, 0, "post_flush");

      // Flush together with a request in IDLE must block the accept.
      in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_a = 64'd9; in_b = 64'd9;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_block", {in_ready, out_valid, busy}, 3'b100);

      // Asynchronous reset during BUSY.
      in_valid = 1'b1; in_op = 3'd3; in_word = 1'b0; in_a = 64'd12345; in_b = 64'd11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("arst_outs", {in_ready, out_valid, busy}, 3'b100);
      chk("arst_data", out_data, 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rdy", {in_ready, busy}, 2'b10);
      run_op(3'd1, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
